// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state encoding, BCD width and per-digit modulus for the lap stopwatch
package stopwatch_pkg;
    localparam int BCD_W = 4;
    typedef enum logic [1:0] {STOPPED, RUNNING, LAP} sw_state_t;
    function automatic int digit_mod(input int idx, input bit sexa);
        return (sexa && idx >= 3 && idx % 2 == 1) ? 6 : 10;
    endfunction
endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one wrapping BCD counter digit counting 0..MAX
module bcd_digit import stopwatch_pkg::*; #(
    parameter int MAX = 9
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             inc,
    output logic [BCD_W-1:0] value,
    output logic             at_max
);
    assign at_max = value == BCD_W'(MAX);
    always_ff @(posedge clk)
        if (!reset_n || clr) value <= '0;
        else if (inc) value <= at_max ? '0 : value + 1'b1;
endmodule

// File: rtl/lap_stopwatch.sv
// lap_stopwatch: BCD stopwatch with prescaler, start/stop and lap-freeze control
module lap_stopwatch import stopwatch_pkg::*; #(
    parameter int NUM_DIGITS  = 4,
    parameter int TICK_DIV    = 1_000_000,
    parameter int SEXAGESIMAL = 0
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        start_stop,
    input  logic                        lap_clear,
    output logic [BCD_W*NUM_DIGITS-1:0] digits,
    output logic                        running,
    output logic                        lap_active,
    output logic                        overflow
);
    localparam int PW = $clog2(TICK_DIV);
    sw_state_t                   state, state_nx;
    logic [PW-1:0]               pre;
    logic                        tick, clr, cap;
    logic [NUM_DIGITS-1:0]       inc, at_max;
    logic [BCD_W*NUM_DIGITS-1:0] count, lap_q;
    assign tick       = state != STOPPED && pre == PW'(TICK_DIV - 1);
    assign running    = state != STOPPED;
    assign lap_active = state == LAP;
    // start_stop always wins over a simultaneous lap_clear
    always_comb begin
        clr      = lap_clear && !start_stop && state == STOPPED;
        cap      = lap_clear && !start_stop && state == RUNNING;
        state_nx = start_stop ? (state == STOPPED ? RUNNING : STOPPED)
                 : cap ? LAP
                 : (lap_clear && state == LAP) ? RUNNING : state;
    end
    always_ff @(posedge clk)
        if (!reset_n) begin
            state    <= STOPPED;
            pre      <= '0;
            lap_q    <= '0;
            digits   <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nx;
            pre      <= (clr || tick) ? '0 : state != STOPPED ? pre + 1'b1 : pre;
            lap_q    <= clr ? '0 : cap ? count : lap_q;
            overflow <= clr ? 1'b0 : (tick && &at_max) ? 1'b1 : overflow;
            digits   <= state == LAP ? lap_q : count;
        end
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        if (i == 0) begin : g_lsd
            assign inc[i] = tick;
        end else begin : g_upper
            assign inc[i] = tick && &at_max[i-1:0];
        end
        bcd_digit #(.MAX(digit_mod(i, SEXAGESIMAL != 0) - 1)) u_digit (
            .clk    (clk),
            .reset_n(reset_n),
            .clr    (clr),
            .inc    (inc[i]),
            .value  (count[i*BCD_W +: BCD_W]),
            .at_max (at_max[i])
        );
    end
endmodule

// File: tb/tb_lap_stopwatch.sv
// tb_lap_stopwatch: randomized and directed checks against an integer-level stopwatch model
module tb_lap_stopwatch;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0, start_stop = 1'b0, lap_clear = 1'b0;
    logic [15:0] digits;
    logic        running, lap_active, overflow;
    logic        rst2_n = 1'b0, ss2 = 1'b0, lc2 = 1'b0;
    logic [23:0] digits2;
    logic        run2, lap2, ov2;
    int          tests = 0, fails = 0;
    bit          chk_en = 1'b0, done2 = 1'b0;
    int          m_state = 0, m_count = 0, m_lap = 0, m_pre = 0, m_ov = 0, old_count;
    logic [15:0] m_disp = '0;

    always #5 clk = ~clk;

    lap_stopwatch #(.NUM_DIGITS(4), .TICK_DIV(4), .SEXAGESIMAL(0)) dut (
        .clk(clk), .reset_n(reset_n), .start_stop(start_stop), .lap_clear(lap_clear),
        .digits(digits), .running(running), .lap_active(lap_active), .overflow(overflow)
    );
    lap_stopwatch #(.NUM_DIGITS(6), .TICK_DIV(2), .SEXAGESIMAL(1)) dut_sexa (
        .clk(clk), .reset_n(rst2_n), .start_stop(ss2), .lap_clear(lc2),
        .digits(digits2), .running(run2), .lap_active(lap2), .overflow(ov2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // model: integer count modulo 10000, states 0=stopped 1=running 2=lap
    always @(posedge clk) begin
        if (!reset_n) begin
            m_state = 0; m_count = 0; m_lap = 0; m_pre = 0; m_ov = 0; m_disp = '0;
        end else begin
            old_count = m_count;
            m_disp = to_bcd(m_state == 2 ? m_lap : m_count);
            if (m_state != 0) begin
                if (m_pre == 3) begin
                    m_pre = 0;
                    if (m_count == 9999) m_ov = 1;
                    m_count = (m_count + 1) % 10000;
                end else m_pre++;
            end
            if (start_stop) m_state = (m_state == 0) ? 1 : 0;
            else if (lap_clear) begin
                if (m_state == 0) begin
                    m_count = 0; m_lap = 0; m_ov = 0; m_pre = 0;
                end else if (m_state == 1) begin
                    m_lap = old_count; m_state = 2;
                end else m_state = 1;
            end
        end
    end

    always @(negedge clk)
        if (chk_en) begin
            check("model_digits", 32'(digits), 32'(m_disp));
            check("model_running", 32'(running), 32'(m_state != 0));
            check("model_lap_active", 32'(lap_active), 32'(m_state == 2));
            check("model_overflow", 32'(overflow), 32'(m_ov));
        end

    task automatic pulse(input logic s, input logic l);
        start_stop = s; lap_clear = l;
        @(negedge clk);
        start_stop = 1'b0; lap_clear = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        rst2_n = 1'b1; ss2 = 1'b1;
        @(negedge clk);
        ss2 = 1'b0;
        wait_cyc(12000);
        check("sexa_before", 32'(digits2), 32'h005999);
        wait_cyc(1);
        check("sexa_rollover", 32'(digits2), 32'h010000);
        done2 = 1'b1;
    end

    initial begin
        @(negedge clk);
        do_reset();
        chk_en = 1'b1;
        check("reset_digits", 32'(digits), 32'h0);
        check("reset_running", 32'(running), 32'h0);
        pulse(1'b1, 1'b0);
        wait_cyc(41);
        check("run40_digits", 32'(digits), 32'h0010);
        check("run40_running", 32'(running), 32'h1);
        do_reset();
        pulse(1'b1, 1'b0);
        wait_cyc(32);
        pulse(1'b0, 1'b1);
        wait_cyc(33);
        check("lap_frozen", 32'(digits), 32'h0008);
        check("lap_active", 32'(lap_active), 32'h1);
        pulse(1'b0, 1'b1);
        wait_cyc(1);
        check("lap_release", 32'(digits), 32'h0016);
        pulse(1'b1, 1'b1);
        wait_cyc(1);
        check("both_digits", 32'(digits), 32'h0017);
        check("both_running", 32'(running), 32'h0);
        check("both_lap", 32'(lap_active), 32'h0);
        do_reset();
        pulse(1'b1, 1'b0);
        wait_cyc(5);
        pulse(1'b0, 1'b1);
        wait_cyc(3);
        check("in_lap", 32'(lap_active), 32'h1);
        do_reset();
        check("lap_rst_digits", 32'(digits), 32'h0);
        check("lap_rst_running", 32'(running), 32'h0);
        check("lap_rst_lap", 32'(lap_active), 32'h0);
        check("lap_rst_ovf", 32'(overflow), 32'h0);
        for (int i = 0; i < 3000; i++) begin
            start_stop = ($urandom_range(0, 15) == 0);
            lap_clear  = ($urandom_range(0, 7) == 0);
            reset_n    = ($urandom_range(0, 499) != 0);
            @(negedge clk);
        end
        start_stop = 1'b0; lap_clear = 1'b0; reset_n = 1'b1;
        do_reset();
        pulse(1'b1, 1'b0);
        wait_cyc(39999);
        check("full_scale", 32'(digits), 32'h9999);
        check("full_no_ovf", 32'(overflow), 32'h0);
        wait_cyc(2);
        check("wrap_digits", 32'(digits), 32'h0);
        check("wrap_ovf", 32'(overflow), 32'h1);
        pulse(1'b1, 1'b0);
        check("ovf_sticky", 32'(overflow), 32'h1);
        pulse(1'b0, 1'b1);
        wait_cyc(1);
        check("clear_ovf", 32'(overflow), 32'h0);
        check("clear_digits", 32'(digits), 32'h0);
        for (int i = 0; i < 100 && !done2; i++) @(negedge clk);
        check("sexa_done", 32'(done2), 32'h1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
